vga_fb_bridge: RTL and testbench

Parametrised bus subordinate between the system bus and the VGA framebuffer write/read ports.
- Posts framebuffer writes into a FIFO so the bus only stalls when the FIFO is full.
- Supports framebuffer read-back with ordering against posted writes.
- Adds a small control/status register window and error reporting for bad accesses.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_post_fifo.sv | 65 ++++++
 rtl/vga_fb_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_vga_fb_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer bus bridge: read-FSM states,
// register-window offsets and CTRL/STATUS bit positions.
package vga_pkg;

    // States of the framebuffer read sequencer
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_DRAIN = 2'd1,
        RD_WAIT  = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

    // Byte offsets inside the register window
    localparam int CTRL_OFFSET   = 'h0;
    localparam int STATUS_OFFSET = 'h4;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    // STATUS field positions
    localparam int STATUS_COUNT_WIDTH = 8;
    localparam int STATUS_FULL_BIT    = 8;
    localparam int STATUS_EMPTY_BIT   = 9;

endpackage

// File: rtl/vga_post_fifo.sv
// Posted-write FIFO: synchronous, power-of-two depth, flush that overrides
// any same-cycle push/pop, and push+pop allowed together while full.
module vga_post_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [WIDTH-1:0]     head,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);
    import vga_pkg::*;

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count_q;

    assign count = count_q;
    assign full  = (count_q == CNT_WIDTH'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush returns everything to zero
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/vga_fb_bridge.sv
// Bus subordinate in front of the VGA framebuffer. Writes are posted through
// a small FIFO, reads wait for that FIFO to drain so they observe all earlier
// writes, and a two-register window exposes enable/flush and FIFO status.
module vga_fb_bridge #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int FB_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH    = 4,
    parameter int FB_RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      bus_wen,
    input  logic                      bus_ren,
    input  logic [ADDR_WIDTH-1:0]     bus_addr,
    input  logic [DATA_WIDTH-1:0]     bus_wdata,
    input  logic [DATA_WIDTH/8-1:0]   bus_strobe,
    output logic [DATA_WIDTH-1:0]     bus_rdata,
    output logic                      bus_error,
    output logic                      bus_request_stall,
    output logic                      fb_wen,
    output logic [FB_ADDR_WIDTH-1:0]  fb_waddr,
    output logic [DATA_WIDTH-1:0]     fb_wdata,
    output logic [DATA_WIDTH/8-1:0]   fb_wstrb,
    input  logic                      fb_wready,
    output logic                      fb_ren,
    output logic [FB_ADDR_WIDTH-1:0]  fb_raddr,
    input  logic [DATA_WIDTH-1:0]     fb_rdata
);
    import vga_pkg::*;

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int SEL_BIT     = FB_ADDR_WIDTH + 2;
    localparam int OFF_WIDTH   = FB_ADDR_WIDTH + 2;
    localparam int ENTRY_WIDTH = FB_ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;
    localparam int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_WIDTH   = $clog2(FB_RD_LATENCY + 1);

    localparam logic [OFF_WIDTH-1:0] CTRL_OFF   = OFF_WIDTH'(CTRL_OFFSET);
    localparam logic [OFF_WIDTH-1:0] STATUS_OFF = OFF_WIDTH'(STATUS_OFFSET);
    localparam logic [LAT_WIDTH-1:0] LAT_LAST   = LAT_WIDTH'(FB_RD_LATENCY - 1);

    // Decode results
    logic request;
    logic high_set;
    logic misaligned;
    logic reg_sel;
    logic is_ctrl;
    logic is_status;
    logic addr_error;
    logic fb_wr_req;
    logic fb_rd_req;
    logic ctrl_wr;

    // Control register and FIFO interface
    logic                     ctrl_enable;
    logic                     flush;
    logic                     push;
    logic                     pop;
    logic                     wr_stall;
    logic [ENTRY_WIDTH-1:0]   push_entry;
    logic [ENTRY_WIDTH-1:0]   head_entry;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_WIDTH-1:0]     fifo_count;
    logic [FB_ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_data;
    logic [STRB_WIDTH-1:0]    head_strb;
    logic [FB_ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0]    hold_data;
    logic [STRB_WIDTH-1:0]    hold_strb;

    // Read sequencer
    rd_state_t                state;
    rd_state_t                state_next;
    logic [LAT_WIDTH-1:0]     lat_cnt;
    logic                     rd_stall;
    logic                     rd_capture;
    logic                     rd_complete;
    logic [FB_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    rd_data;

    // Classify the current request and flag anything that must be rejected
    always_comb begin
        request    = bus_wen | bus_ren;
        high_set   = |(bus_addr >> (SEL_BIT + 1));
        misaligned = |bus_addr[1:0];
        reg_sel    = bus_addr[SEL_BIT];
        is_ctrl    = reg_sel && (bus_addr[OFF_WIDTH-1:0] == CTRL_OFF);
        is_status  = reg_sel && (bus_addr[OFF_WIDTH-1:0] == STATUS_OFF);
        addr_error = request && (high_set || misaligned ||
                     (reg_sel && !(is_ctrl || (is_status && bus_ren))));
        fb_wr_req  = bus_wen && !reg_sel && !addr_error;
        fb_rd_req  = bus_ren && !reg_sel && !addr_error;
        ctrl_wr    = bus_wen && is_ctrl && !addr_error;
    end

    // Posting and draining: a full FIFO still accepts a push when it pops
    always_comb begin
        fb_wen     = !fifo_empty && ctrl_enable;
        pop        = fb_wen && fb_wready;
        wr_stall   = fb_wr_req && fifo_full && !pop;
        push       = fb_wr_req && !wr_stall;
        flush      = ctrl_wr && bus_strobe[0] && bus_wdata[CTRL_FLUSH_BIT];
        push_entry = {bus_addr[SEL_BIT-1:2], bus_wdata, bus_strobe};
    end

    assign head_addr = head_entry[ENTRY_WIDTH-1 -: FB_ADDR_WIDTH];
    assign head_data = head_entry[STRB_WIDTH +: DATA_WIDTH];
    assign head_strb = head_entry[STRB_WIDTH-1:0];

    vga_post_fifo #(
        .WIDTH     (ENTRY_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_post_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // CTRL.enable; flush is an action only and is never stored
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ctrl_enable <= 1'b1;
        end else if (ctrl_wr && bus_strobe[0]) begin
            ctrl_enable <= bus_wdata[CTRL_ENABLE_BIT];
        end
    end

    // Remember the last presented write so idle write ports stay steady
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_addr <= '0;
            hold_data <= '0;
            hold_strb <= '0;
        end else if (fb_wen) begin
            hold_addr <= head_addr;
            hold_data <= head_data;
            hold_strb <= head_strb;
        end
    end

    // Write port shows the FIFO head only while it is actually offered
    always_comb begin
        fb_waddr = fb_wen ? head_addr : hold_addr;
        fb_wdata = fb_wen ? head_data : hold_data;
        fb_wstrb = fb_wen ? head_strb : hold_strb;
    end

    // Read sequencer state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read sequencer transitions: drain posted writes, issue, wait, complete
    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE:  if (fb_rd_req)            state_next = RD_DRAIN;
            RD_DRAIN: if (fifo_empty)           state_next = RD_WAIT;
            RD_WAIT:  if (lat_cnt == LAT_LAST)  state_next = RD_DONE;
            RD_DONE:                            state_next = RD_IDLE;
            default:                            state_next = RD_IDLE;
        endcase
    end

    // Read sequencer outputs
    always_comb begin
        rd_stall    = 1'b0;
        fb_ren      = 1'b0;
        rd_capture  = 1'b0;
        rd_complete = 1'b0;
        case (state)
            RD_IDLE: begin
                rd_stall = fb_rd_req;
            end
            RD_DRAIN: begin
                rd_stall = 1'b1;
                fb_ren   = fifo_empty;
            end
            RD_WAIT: begin
                rd_stall   = 1'b1;
                rd_capture = (lat_cnt == LAT_LAST);
            end
            RD_DONE: begin
                rd_complete = 1'b1;
            end
            default: begin
                rd_stall = 1'b0;
            end
        endcase
    end

    // Latency counter restarts every time the sequencer is draining
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lat_cnt <= '0;
        end else if (state == RD_DRAIN) begin
            lat_cnt <= '0;
        end else if (state == RD_WAIT) begin
            lat_cnt <= lat_cnt + LAT_WIDTH'(1);
        end
    end

    // Latch the read word address when the read is accepted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_addr <= '0;
        end else if ((state == RD_IDLE) && fb_rd_req) begin
            rd_addr <= bus_addr[SEL_BIT-1:2];
        end
    end

    assign fb_raddr = rd_addr;

    // Capture framebuffer data in the last latency cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data <= '0;
        end else if (rd_capture) begin
            rd_data <= fb_rdata;
        end
    end

    // Read data mux: registers complete at once, framebuffer reads in RD_DONE
    always_comb begin
        bus_rdata = '0;
        if (bus_ren && !addr_error) begin
            if (is_ctrl) begin
                bus_rdata[CTRL_ENABLE_BIT] = ctrl_enable;
            end else if (is_status) begin
                bus_rdata[STATUS_COUNT_WIDTH-1:0] = STATUS_COUNT_WIDTH'(fifo_count);
                bus_rdata[STATUS_FULL_BIT]        = fifo_full;
                bus_rdata[STATUS_EMPTY_BIT]       = fifo_empty;
            end else if (rd_complete) begin
                bus_rdata = rd_data;
            end
        end
    end

    assign bus_error         = addr_error;
    assign bus_request_stall = wr_stall | rd_stall;

endmodule

// File: tb/tb_vga_fb_bridge.sv
// Self-checking bench for vga_fb_bridge: a table of single bus accesses with
// expected error/read-data/stall-cycle results, plus hand-written sequences
// for FIFO back-pressure, read ordering, enable/flush and mid-read reset.
module tb_vga_fb_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int FAW = 17;
    localparam int DEP = 4;
    localparam int LAT = 2;
    localparam int SW  = DW / 8;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           bus_wen;
    logic           bus_ren;
    logic [AW-1:0]  bus_addr;
    logic [DW-1:0]  bus_wdata;
    logic [SW-1:0]  bus_strobe;
    logic [DW-1:0]  bus_rdata;
    logic           bus_error;
    logic           bus_request_stall;
    logic           fb_wen;
    logic [FAW-1:0] fb_waddr;
    logic [DW-1:0]  fb_wdata;
    logic [SW-1:0]  fb_wstrb;
    logic           fb_wready;
    logic           fb_ren;
    logic [FAW-1:0] fb_raddr;
    logic [DW-1:0]  fb_rdata;

    int passed_checks = 0;
    int total_checks  = 0;

    always #5 clk = ~clk;

    vga_fb_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .FB_ADDR_WIDTH (FAW),
        .FIFO_DEPTH    (DEP),
        .FB_RD_LATENCY (LAT)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .bus_wen           (bus_wen),
        .bus_ren           (bus_ren),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_strobe        (bus_strobe),
        .bus_rdata         (bus_rdata),
        .bus_error         (bus_error),
        .bus_request_stall (bus_request_stall),
        .fb_wen            (fb_wen),
        .fb_waddr          (fb_waddr),
        .fb_wdata          (fb_wdata),
        .fb_wstrb          (fb_wstrb),
        .fb_wready         (fb_wready),
        .fb_ren            (fb_ren),
        .fb_raddr          (fb_raddr),
        .fb_rdata          (fb_rdata)
    );

    // Framebuffer model: word 4 holds 0xDEADBEEF, others a tagged pattern
    function automatic logic [DW-1:0] fb_model(input logic [FAW-1:0] a);
        return (a == FAW'(4)) ? 32'hDEADBEEF : (32'hA500_0000 | DW'(a));
    endfunction

    // Accepted framebuffer writes and read-pulse history, sampled mid-cycle
    logic [FAW-1:0] obs_addr[$];
    logic [DW-1:0]  obs_data[$];
    logic [SW-1:0]  obs_strb[$];
    int             ren_total = 0;
    logic [LAT:0]   ren_pipe = '0;
    logic [FAW-1:0] raddr_pipe [0:LAT];

    always @(negedge clk) begin
        #2;
        if (fb_wen && fb_wready) begin
            obs_addr.push_back(fb_waddr);
            obs_data.push_back(fb_wdata);
            obs_strb.push_back(fb_wstrb);
        end
        if (fb_ren) ren_total++;
        for (int i = LAT; i > 0; i--) begin
            ren_pipe[i]   = ren_pipe[i-1];
            raddr_pipe[i] = raddr_pipe[i-1];
        end
        ren_pipe[0]   = fb_ren;
        raddr_pipe[0] = fb_raddr;
    end

    assign fb_rdata = ren_pipe[LAT] ? fb_model(raddr_pipe[LAT]) : 32'h0BAD_F00D;

    typedef struct {
        logic          wen;
        logic          ren;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_cycles;
        string         name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic wen, input logic ren, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic err, input logic [DW-1:0] rdata, input int cyc,
                           input string name);
        vec_t v;
        v.wen = wen; v.ren = ren; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.exp_err = err; v.exp_rdata = rdata; v.exp_cycles = cyc; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input logic [DW-1:0] actual,
                                input logic [DW-1:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // One bus access, held until it completes or the cycle budget runs out
    task automatic apply_stimulus(input logic wen, input logic ren, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                  input string name, output logic [DW-1:0] rdata,
                                  output logic err, output int cycles);
        @(negedge clk);
        bus_wen = wen; bus_ren = ren; bus_addr = addr; bus_wdata = wdata; bus_strobe = strb;
        #1;
        cycles = 0;
        while (bus_request_stall && cycles < 30) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check_output({name, "_completed"}, DW'(bus_request_stall), 0);
        rdata = bus_rdata;
        err   = bus_error;
        @(posedge clk);
        #1;
        bus_wen = 1'b0;
        bus_ren = 1'b0;
    endtask

    task automatic run_vecs(input int first, input int last);
        logic [DW-1:0] rd;
        logic          er;
        int            cy;
        for (int i = first; i <= last; i++) begin
            apply_stimulus(vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wdata,
                           vecs[i].strb, vecs[i].name, rd, er, cy);
            check_output({vecs[i].name, "_err"}, DW'(er), DW'(vecs[i].exp_err));
            check_output({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check_output({vecs[i].name, "_cycles"}, DW'(cy), DW'(vecs[i].exp_cycles));
        end
    endtask

    task automatic check_log(input int idx, input logic [FAW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input string name);
        if (idx < obs_addr.size()) begin
            check_output({name, "_waddr"}, DW'(obs_addr[idx]), DW'(a));
            check_output({name, "_wdata"}, obs_data[idx], d);
            check_output({name, "_wstrb"}, DW'(obs_strb[idx]), DW'(s));
        end else begin
            check_output({name, "_present"}, DW'(obs_addr.size()), DW'(idx + 1));
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_output({tag, "_fb_wen"},    DW'(fb_wen), 0);
        check_output({tag, "_fb_ren"},    DW'(fb_ren), 0);
        check_output({tag, "_fb_waddr"},  DW'(fb_waddr), 0);
        check_output({tag, "_fb_wdata"},  fb_wdata, 0);
        check_output({tag, "_fb_wstrb"},  DW'(fb_wstrb), 0);
        check_output({tag, "_fb_raddr"},  DW'(fb_raddr), 0);
        check_output({tag, "_bus_rdata"}, bus_rdata, 0);
        check_output({tag, "_bus_error"}, DW'(bus_error), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            cy;
        int            ren_cycle;
        int            done_cycle;
        int            log_at_ren;
        int            ren_before;
        int            log_before;

        n_rst = 1'b0; bus_wen = 1'b0; bus_ren = 1'b0; bus_addr = '0;
        bus_wdata = '0; bus_strobe = '0; fb_wready = 1'b0;

        // Vectors 0-6: posted writes, register reads, empty-FIFO read latency
        add_vec(1, 0, 32'h0000_0000, 32'h1111_1111, 4'hF, 0, 0, 0, "t1_wr0");
        add_vec(1, 0, 32'h0000_0004, 32'h2222_2222, 4'h1, 0, 0, 0, "t1_wr1");
        add_vec(1, 0, 32'h0000_0008, 32'h3333_3333, 4'h6, 0, 0, 0, "t1_wr2");
        add_vec(1, 0, 32'h0000_000C, 32'h4444_4444, 4'h8, 0, 0, 0, "t1_wr3");
        add_vec(0, 1, 32'h0008_0000, 0, 4'hF, 0, 32'h0000_0001, 0, "t1_ctrl_rd");
        add_vec(0, 1, 32'h0008_0004, 0, 4'hF, 0, 32'h0000_0200, 0, "t1_status_empty");
        add_vec(0, 1, 32'h0000_0014, 0, 4'hF, 0, 32'hA500_0005, LAT + 2, "rd_empty_fifo");
        // Vectors 7-11: fill the FIFO with the framebuffer not ready
        add_vec(1, 0, 32'h0000_0100, 32'h5000_0000, 4'hF, 0, 0, 0, "t2_wr0");
        add_vec(1, 0, 32'h0000_0104, 32'h5000_0001, 4'hF, 0, 0, 0, "t2_wr1");
        add_vec(1, 0, 32'h0000_0108, 32'h5000_0002, 4'hF, 0, 0, 0, "t2_wr2");
        add_vec(1, 0, 32'h0000_010C, 32'h5000_0003, 4'hF, 0, 0, 0, "t2_wr3");
        add_vec(0, 1, 32'h0008_0004, 0, 4'hF, 0, 32'h0000_0104, 0, "t2_status_full");
        // Vectors 12-21: bad accesses with a full FIFO, then confirm no side effect
        add_vec(1, 0, 32'h0008_0004, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, "t5_wr_status");
        add_vec(0, 1, 32'h0008_0008, 0, 4'hF, 1, 0, 0, "t5_rd_off8");
        add_vec(1, 0, 32'h0008_0008, 32'h0000_0002, 4'hF, 1, 0, 0, "t5_wr_off8");
        add_vec(0, 1, 32'h0000_0002, 0, 4'hF, 1, 0, 0, "t5_rd_misaligned");
        add_vec(1, 0, 32'h0000_0002, 32'h1234_5678, 4'hF, 1, 0, 0, "t5_wr_misaligned");
        add_vec(0, 1, 32'h0010_0000, 0, 4'hF, 1, 0, 0, "t5_rd_high");
        add_vec(1, 0, 32'h0010_0000, 32'h1234_5678, 4'hF, 1, 0, 0, "t5_wr_high");
        add_vec(1, 0, 32'h0008_0001, 32'h0000_0002, 4'hF, 1, 0, 0, "t5_wr_ctrl_misaligned");
        add_vec(0, 1, 32'h0008_0004, 0, 4'hF, 0, 32'h0000_0104, 0, "t5_status_unchanged");
        add_vec(0, 1, 32'h0008_0000, 0, 4'hF, 0, 32'h0000_0001, 0, "t5_ctrl_unchanged");

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_quiet_outputs("reset");
        @(negedge clk);
        n_rst = 1'b1;
        fb_wready = 1'b1;

        // Writes drain in order, then registers and an empty-FIFO read
        run_vecs(0, 6);
        repeat (3) @(negedge clk);
        check_log(0, 17'd0, 32'h1111_1111, 4'hF, "t1_log0");
        check_log(1, 17'd1, 32'h2222_2222, 4'h1, "t1_log1");
        check_log(2, 17'd2, 32'h3333_3333, 4'h6, "t1_log2");
        check_log(3, 17'd3, 32'h4444_4444, 4'h8, "t1_log3");

        // Back-pressure: fill, probe errors, then a fifth write completes on the pop
        fb_wready = 1'b0;
        run_vecs(7, 21);
        @(negedge clk);
        bus_wen = 1'b1; bus_addr = 32'h0000_0110; bus_wdata = 32'h5000_0004; bus_strobe = 4'hF;
        #1;
        check_output("t2_fifth_stall_a", DW'(bus_request_stall), 1);
        @(negedge clk);
        #1;
        check_output("t2_fifth_stall_b", DW'(bus_request_stall), 1);
        @(negedge clk);
        fb_wready = 1'b1;
        #1;
        check_output("t2_fifth_no_stall_on_pop", DW'(bus_request_stall), 0);
        check_output("t2_fifth_err", DW'(bus_error), 0);
        @(posedge clk);
        #1;
        bus_wen = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_log(4 + i, FAW'(32'h40 + i), 32'h5000_0000 + DW'(i), 4'hF, "t2_log");
        end

        // Read ordering: two queued writes must reach the framebuffer first
        fb_wready = 1'b0;
        apply_stimulus(1, 0, 32'h0000_0200, 32'h6000_0000, 4'h3, "t3_wr0", rd, er, cy);
        check_output("t3_wr0_cycles", DW'(cy), 0);
        apply_stimulus(1, 0, 32'h0000_0204, 32'h6000_0001, 4'hC, "t3_wr1", rd, er, cy);
        check_output("t3_wr1_cycles", DW'(cy), 0);
        ren_cycle = -1; done_cycle = -1; log_at_ren = -1;
        @(negedge clk);
        bus_ren = 1'b1; bus_addr = 32'h0000_0010;
        for (int c = 0; c < 40 && done_cycle < 0; c++) begin
            if (c == 3) fb_wready = 1'b1;
            #1;
            if (fb_ren && ren_cycle < 0) begin
                ren_cycle  = c;
                log_at_ren = obs_addr.size();
            end
            if (!bus_request_stall) begin
                done_cycle = c;
                rd = bus_rdata;
                er = bus_error;
            end
            @(negedge clk);
        end
        bus_ren = 1'b0;
        check_output("t3_fb_ren_cycle", DW'(ren_cycle), 5);
        check_output("t3_drained_before_ren", DW'(log_at_ren), 11);
        check_output("t3_done_cycle", DW'(done_cycle), 8);
        check_output("t3_ren_to_done", DW'(done_cycle - ren_cycle), LAT + 1);
        check_output("t3_rdata", rd, 32'hDEADBEEF);
        check_output("t3_err", DW'(er), 0);
        check_log(9,  17'h80, 32'h6000_0000, 4'h3, "t3_log0");
        check_log(10, 17'h81, 32'h6000_0001, 4'hC, "t3_log1");

        // Disable draining, queue writes, flush them away
        apply_stimulus(1, 0, 32'h0008_0000, 32'h0000_0000, 4'hF, "t4_disable", rd, er, cy);
        check_output("t4_disable_err", DW'(er), 0);
        apply_stimulus(1, 0, 32'h0000_0300, 32'h7000_0000, 4'hF, "t4_wr0", rd, er, cy);
        apply_stimulus(1, 0, 32'h0000_0304, 32'h7000_0001, 4'hF, "t4_wr1", rd, er, cy);
        repeat (4) @(negedge clk);
        #1;
        check_output("t4_fb_wen_off", DW'(fb_wen), 0);
        check_output("t4_hold_wdata", fb_wdata, 32'h6000_0001);
        check_output("t4_hold_waddr", DW'(fb_waddr), 32'h81);
        apply_stimulus(0, 1, 32'h0008_0004, 0, 4'hF, "t4_status_q", rd, er, cy);
        check_output("t4_status_queued", rd, 32'h0000_0002);
        apply_stimulus(1, 0, 32'h0008_0000, 32'h0000_0002, 4'hF, "t4_flush", rd, er, cy);
        check_output("t4_flush_err", DW'(er), 0);
        apply_stimulus(0, 1, 32'h0008_0004, 0, 4'hF, "t4_status_f", rd, er, cy);
        check_output("t4_status_flushed", rd, 32'h0000_0200);
        apply_stimulus(0, 1, 32'h0008_0000, 0, 4'hF, "t4_ctrl_rd", rd, er, cy);
        check_output("t4_ctrl_reads_zero", rd, 32'h0000_0000);
        apply_stimulus(1, 0, 32'h0008_0000, 32'h0000_0001, 4'hF, "t4_enable", rd, er, cy);
        repeat (4) @(negedge clk);
        check_output("t4_nothing_drained", DW'(obs_addr.size()), 11);

        // Reset while a read waits behind queued writes
        fb_wready = 1'b0;
        apply_stimulus(1, 0, 32'h0000_0400, 32'h8000_0000, 4'hF, "t6_wr0", rd, er, cy);
        apply_stimulus(1, 0, 32'h0000_0404, 32'h8000_0001, 4'hF, "t6_wr1", rd, er, cy);
        @(negedge clk);
        bus_ren = 1'b1; bus_addr = 32'h0000_0018;
        #1;
        check_output("t6_read_stalls", DW'(bus_request_stall), 1);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        bus_ren = 1'b0; bus_addr = '0; bus_wdata = '0; bus_strobe = '0;
        #1;
        check_quiet_outputs("t6_in_reset");
        ren_before = ren_total;
        log_before = obs_addr.size();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        fb_wready = 1'b1;
        repeat (5) @(negedge clk);
        check_output("t6_no_fb_ren", DW'(ren_total), DW'(ren_before));
        check_output("t6_no_fb_wen", DW'(obs_addr.size()), DW'(log_before));
        apply_stimulus(0, 1, 32'h0008_0004, 0, 4'hF, "t6_status", rd, er, cy);
        check_output("t6_status_empty", rd, 32'h0000_0200);
        apply_stimulus(0, 1, 32'h0008_0000, 0, 4'hF, "t6_ctrl", rd, er, cy);
        check_output("t6_ctrl_enable", rd, 32'h0000_0001);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
